point_batch_feeder: RTL and testbench
=====================================

# point_batch_feeder

Parametrised successor to the point feeder in the LiDAR denoising datapath. It holds a window of up to DEPTH (x,y,z) points in banked storage. For every reference point it streams that point, plus all window points in batches of MODULES lanes, to the distance-module array. Output uses a valid/ready handshake, per-lane valid masking and optional self-exclusion, replacing the former unconditional one-cycle register copy.

## Interface
- N, 16, coordinate width (signed two's complement, passed through untouched)
- MODULES, 32, lanes per batch (number of distance modules); power of two
- DEPTH, 256, window capacity; multiple of MODULES
- SKIP_SELF, 1, when 1 the lane carrying the reference point itself is masked invalid
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin a feed run (sampled in IDLE only)
- num_points  in  $clog2(DEPTH)+1  points in window, latched on start
- wr_en  in  1  point write strobe
- wr_addr  in  $clog2(DEPTH)  point index
- wr_x, wr_y, wr_z  in  N  point coordinates
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at run end
- out_valid  in/out: out  1  batch beat valid
- out_ready  in  1  downstream accepts beat
- ref_x, ref_y, ref_z  out  N  reference point
- ref_idx  out  $clog2(DEPTH)  reference point index
- cp_x, cp_y, cp_z  out  N*MODULES  candidate points; lane k in bits [k*N +: N]
- lane_valid  out  MODULES  per-lane valid
- last_batch  out  1  beat is final batch for this ref_idx

## Operation
- Storage: point i sits in bank i%MODULES, row i/MODULES. Writes are accepted in IDLE only; wr_en in FEED is ignored. Storage is not reset.
- FSM states: IDLE, FEED, FLUSH.
- IDLE -> FEED: on start. Latches cnt = min(num_points, DEPTH), sets r=0, b=0.
- start with num_points==0: go straight to FLUSH; no beats.
- FEED: each time the output register is free (!out_valid || out_ready), load a beat (r,b):
  - ref = point r
  - cp lane k = point b*MODULES+k
  - lane_valid[k] = (b*MODULES+k < cnt) && !(SKIP_SELF && b*MODULES+k == r)
  - last_batch = (b == nb-1), where nb = ceil(cnt/MODULES)
- Advance: b increments; on wrap b=0 and r increments. After beat (cnt-1, nb-1) is loaded, go to FLUSH.
- FLUSH: wait until the last beat handshakes (out_valid && out_ready), then pulse done, go IDLE.
- start while busy is ignored.
- Lanes that are not valid still carry stored data; downstream must gate on lane_valid.

## Timing
- Reset values: all outputs 0, state IDLE, busy 0.
- Reset asserted mid-run aborts immediately: outputs 0 and no done pulse.
- start sampled at edge T: busy=1 after T. First out_valid=1 after edge T+1.
- With out_ready held high, one beat per cycle: total beats = cnt*nb, no bubbles.
- Backpressure: while out_valid && !out_ready, every output holds stable.
- done=1 the cycle after the final handshake edge; busy falls on that same edge. A new start is accepted the cycle done is high.
- cnt==0: done pulses 2 cycles after start with no out_valid.

## Structure
- Shared package holds:
  - N, MODULES, DEPTH defaults
  - derived ADDR_W = $clog2(DEPTH) and BANK_W = $clog2(MODULES)
  - state enum {IDLE, FEED, FLUSH}
  - point struct {x, y, z}
- One sub-module, point_bank: one bank of DEPTH/MODULES rows with a synchronous write port and combinational read port. Instantiate MODULES of them via generate.
- The reference point is read through a MODULES:1 mux from the bank outputs at row r/MODULES.

## Test plan
Parameters for all cases: MODULES=4, DEPTH=16.
- Load points i=(i,2i,3i); start with num_points=8, SKIP_SELF=1, out_ready=1 -> 16 beats.
  - Beat 0: ref_idx 0, lane_valid 4'b1110, cp_x lanes {3,2,1,0}.
  - Beat 1: lane_valid 4'b1111, last_batch=1.
  - done 1 cycle after beat 15.
- num_points=6 -> batch 1 lane_valid 4'b0011 (lanes 4,5), or 4'b0010 when ref_idx=4; 12 beats.
- Toggle out_ready 1,0,0,1 each cycle during a run -> outputs stable while stalled, no beat lost or duplicated, beat count = cnt*nb.
- num_points=0 -> done 2 cycles after start, out_valid never 1. num_points=20 -> clamped to 16, 64 beats.
- resetn low mid-FEED -> all outputs 0 asynchronously, no done. A following start with num_points=4 and out_ready=1 runs 4 clean beats on the retained storage.
- Writes and a second start during FEED -> ignored; stored data unchanged and beat sequence unaffected.

Source files
------------

// File: rtl/point_batch_feeder_pkg.sv
// point_batch_feeder shared definitions
// Defaults, derived widths, FSM states and point record.
package point_batch_feeder_pkg;

    localparam int DEF_N       = 16;
    localparam int DEF_MODULES = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int ADDR_W      = $clog2(DEF_DEPTH);
    localparam int BANK_W      = $clog2(DEF_MODULES);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [DEF_N-1:0] x;
        logic [DEF_N-1:0] y;
        logic [DEF_N-1:0] z;
    } point_t;

endpackage

// File: rtl/point_bank.sv
// point_bank: one storage bank of the point window
// Sync write, two combinational reads (candidate row, reference row).
module point_bank #(
    parameter int N    = 16,
    parameter int ROWS = 8,
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [RW-1:0] wr_row,
    input  logic [3*N-1:0] wr_pt,
    input  logic [RW-1:0] cp_row,
    output logic [3*N-1:0] cp_pt,
    input  logic [RW-1:0] ref_row,
    output logic [3*N-1:0] ref_pt
);

    logic [3*N-1:0] mem [ROWS];

    // storage write; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (we) mem[wr_row] <= wr_pt;
    end

    assign cp_pt  = mem[cp_row];
    assign ref_pt = mem[ref_row];

endmodule

// File: rtl/point_batch_feeder.sv
// point_batch_feeder: streams ref point + batched window points
// Registered valid/ready output with per-lane masking.
module point_batch_feeder
    import point_batch_feeder_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int MODULES   = DEF_MODULES,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit SKIP_SELF = 1'b1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_points,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [N-1:0]               wr_x,
    input  logic [N-1:0]               wr_y,
    input  logic [N-1:0]               wr_z,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               ref_x,
    output logic [N-1:0]               ref_y,
    output logic [N-1:0]               ref_z,
    output logic [$clog2(DEPTH)-1:0]   ref_idx,
    output logic [N*MODULES-1:0]       cp_x,
    output logic [N*MODULES-1:0]       cp_y,
    output logic [N*MODULES-1:0]       cp_z,
    output logic [MODULES-1:0]         lane_valid,
    output logic                       last_batch
);

    localparam int AW   = $clog2(DEPTH);
    localparam int BW   = $clog2(MODULES);
    localparam int RW   = AW - BW;
    localparam int ROWS = DEPTH / MODULES;

    state_t            state_q, state_n;
    logic [AW:0]       cnt_q, cnt_n, clamp, nb_full;
    logic [RW-1:0]     nbl_q, nbl_n, b_q, b_n;
    logic [AW-1:0]     r_q, r_n, idx;
    logic              free, last_beat;
    logic [3*N-1:0]    cp_pt [MODULES];
    logic [3*N-1:0]    rf_pt [MODULES];
    logic [3*N-1:0]    sel_ref;

    logic              ov_n, done_n, lb_n;
    logic [N-1:0]      rx_n, ry_n, rz_n;
    logic [AW-1:0]     ridx_n;
    logic [N*MODULES-1:0] cpx_n, cpy_n, cpz_n;
    logic [MODULES-1:0]   lv_n;

    for (genvar k = 0; k < MODULES; k++) begin : g_bank
        point_bank #(
            .N    (N),
            .ROWS (ROWS)
        ) u_bank (
            .clock   (clock),
            .we      (wr_en && state_q == IDLE && wr_addr[BW-1:0] == BW'(k)),
            .wr_row  (wr_addr[AW-1:BW]),
            .wr_pt   ({wr_x, wr_y, wr_z}),
            .cp_row  (b_q),
            .cp_pt   (cp_pt[k]),
            .ref_row (r_q[AW-1:BW]),
            .ref_pt  (rf_pt[k])
        );
    end

    assign busy = (state_q != IDLE);

    // next-state, beat assembly and (ref, batch) sequencing
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        nbl_n   = nbl_q;
        r_n     = r_q;
        b_n     = b_q;
        ov_n    = out_valid;
        done_n  = 1'b0;
        lb_n    = last_batch;
        rx_n    = ref_x;
        ry_n    = ref_y;
        rz_n    = ref_z;
        ridx_n  = ref_idx;
        cpx_n   = cp_x;
        cpy_n   = cp_y;
        cpz_n   = cp_z;
        lv_n    = lane_valid;
        idx     = '0;
        clamp   = (num_points > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_points;
        nb_full = (clamp + (AW+1)'(MODULES - 1)) >> BW;
        free    = !out_valid || out_ready;
        last_beat = (r_q == AW'(cnt_q - 1'b1)) && (b_q == nbl_q);
        sel_ref = rf_pt[r_q[BW-1:0]];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_n   = clamp;
                    nbl_n   = RW'(nb_full - 1'b1);
                    r_n     = '0;
                    b_n     = '0;
                    state_n = (clamp == '0) ? FLUSH : FEED;
                end
            end
            FEED: begin
                if (free) begin
                    ov_n   = 1'b1;
                    ridx_n = r_q;
                    rx_n   = sel_ref[3*N-1 -: N];
                    ry_n   = sel_ref[2*N-1 -: N];
                    rz_n   = sel_ref[N-1:0];
                    lb_n   = (b_q == nbl_q);
                    for (int k = 0; k < MODULES; k++) begin
                        idx = {b_q, BW'(k)};
                        cpx_n[k*N +: N] = cp_pt[k][3*N-1 -: N];
                        cpy_n[k*N +: N] = cp_pt[k][2*N-1 -: N];
                        cpz_n[k*N +: N] = cp_pt[k][N-1:0];
                        lv_n[k] = ({1'b0, idx} < cnt_q)
                                  && !(SKIP_SELF && idx == r_q);
                    end
                    if (b_q == nbl_q) begin
                        b_n = '0;
                        r_n = r_q + 1'b1;
                    end else begin
                        b_n = b_q + 1'b1;
                    end
                    if (last_beat) state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (free) begin
                    ov_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output register bank; reset clears every output
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nbl_q      <= '0;
            r_q        <= '0;
            b_q        <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            last_batch <= 1'b0;
            ref_x      <= '0;
            ref_y      <= '0;
            ref_z      <= '0;
            ref_idx    <= '0;
            cp_x       <= '0;
            cp_y       <= '0;
            cp_z       <= '0;
            lane_valid <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            nbl_q      <= nbl_n;
            r_q        <= r_n;
            b_q        <= b_n;
            out_valid  <= ov_n;
            done       <= done_n;
            last_batch <= lb_n;
            ref_x      <= rx_n;
            ref_y      <= ry_n;
            ref_z      <= rz_n;
            ref_idx    <= ridx_n;
            cp_x       <= cpx_n;
            cp_y       <= cpy_n;
            cp_z       <= cpz_n;
            lane_valid <= lv_n;
        end
    end

endmodule

// File: tb/tb_point_batch_feeder.sv
// tb_point_batch_feeder: scoreboard bench, MODULES=4 DEPTH=16
// Expected beats queued at start, popped on each handshake.
module tb_point_batch_feeder;
    import point_batch_feeder_pkg::*;

    localparam int N = 16;
    localparam int M = 4;
    localparam int D = 16;

    typedef struct packed {
        logic [3:0]     idx;
        logic [3*N-1:0] rf;
        logic [N*M-1:0] cx;
        logic [N*M-1:0] cy;
        logic [N*M-1:0] cz;
        logic [M-1:0]   lv;
        logic           lb;
    } beat_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic [4:0] num_points = '0;
    logic wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [N-1:0] wr_x = '0, wr_y = '0, wr_z = '0;
    logic out_ready = 1'b1;
    logic busy, done, out_valid, last_batch;
    logic [N-1:0] ref_x, ref_y, ref_z;
    logic [3:0] ref_idx;
    logic [N*M-1:0] cp_x, cp_y, cp_z;
    logic [M-1:0] lane_valid;

    point_t mem_m [D];
    beat_t  q [$];
    int checks = 0;
    int errors = 0;
    int beats = 0;

    logic [251:0] all_out;
    logic [249:0] snap, snap_prev;
    logic stall_prev = 1'b0;
    beat_t got, exp_b;

    assign all_out = {busy, done, out_valid, ref_x, ref_y, ref_z, ref_idx,
                      cp_x, cp_y, cp_z, lane_valid, last_batch};
    assign snap = {out_valid, ref_idx, ref_x, ref_y, ref_z,
                   cp_x, cp_y, cp_z, lane_valid, last_batch};

    point_batch_feeder #(
        .N(N), .MODULES(M), .DEPTH(D), .SKIP_SELF(1'b1)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .num_points(num_points), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z),
        .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .ref_x(ref_x), .ref_y(ref_y),
        .ref_z(ref_z), .ref_idx(ref_idx), .cp_x(cp_x), .cp_y(cp_y),
        .cp_z(cp_z), .lane_valid(lane_valid), .last_batch(last_batch)
    );

    always #5 clock = ~clock;

    // scoreboard pop on handshake, hold check while stalled
    always @(negedge clock) begin
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (snap !== snap_prev) begin
                    errors++;
                    $display("FAIL stall_hold got %h exp %h", snap, snap_prev);
                end
            end
            stall_prev = out_valid && !out_ready;
            snap_prev = snap;
            if (out_valid && out_ready) begin
                checks++;
                beats++;
                got = {ref_idx, ref_x, ref_y, ref_z, cp_x, cp_y, cp_z,
                       lane_valid, last_batch};
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got %h exp none", got);
                end else begin
                    exp_b = q.pop_front();
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL beat got %h exp %h", got, exp_b);
                    end
                end
            end
        end
    end

    task automatic push_model(input int n);
        int cnt, nb, i;
        beat_t e;
        cnt = (n > D) ? D : n;
        nb = (cnt + M - 1) / M;
        for (int r = 0; r < cnt; r++) begin
            for (int b = 0; b < nb; b++) begin
                e = '0;
                e.idx = 4'(r);
                e.rf = mem_m[r];
                e.lb = (b == nb - 1);
                for (int k = 0; k < M; k++) begin
                    i = b * M + k;
                    e.cx[k*N +: N] = mem_m[i].x;
                    e.cy[k*N +: N] = mem_m[i].y;
                    e.cz[k*N +: N] = mem_m[i].z;
                    e.lv[k] = (i < cnt) && (i != r);
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic do_start(input int n);
        @(posedge clock); #2;
        start = 1'b1;
        num_points = 5'(n);
        push_model(n);
        beats = 0;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, input bit toggle,
                             output int cyc, output bit got_done,
                             output bit last_hs, output bit vseen);
        logic [3:0] pat;
        pat = 4'b1001;
        cyc = cyc0;
        got_done = 1'b0;
        last_hs = 1'b0;
        vseen = 1'b0;
        while (cyc < cyc0 + 200) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            vseen = vseen | out_valid;
            last_hs = out_valid && out_ready;
            @(posedge clock); #2;
            if (toggle) out_ready = pat[cyc % 4];
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;
    endtask

    task automatic load_points();
        for (int i = 0; i < D; i++) begin
            @(posedge clock); #2;
            wr_en = 1'b1;
            wr_addr = 4'(i);
            wr_x = 16'(i);
            wr_y = 16'(2 * i);
            wr_z = 16'(3 * i);
            mem_m[i] = {16'(i), 16'(2 * i), 16'(3 * i)};
        end
        @(posedge clock); #2 wr_en = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        bit gd, lh, vs;
        out_ready = 1'b1;
        do_start(8);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_cycle got busy=%b valid=%b exp busy=1 valid=0",
                     busy, out_valid);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || ref_idx !== 4'd0 || lane_valid !== 4'b1110
            || cp_x !== {16'd3, 16'd2, 16'd1, 16'd0} || last_batch !== 1'b0) begin
            errors++;
            $display("FAIL basic_beat0 got v=%b idx=%0d lv=%b cpx=%h lb=%b exp 1 0 1110 0003000200010000 0",
                     out_valid, ref_idx, lane_valid, cp_x, last_batch);
        end
        @(negedge clock);
        checks++;
        if (lane_valid !== 4'b1111 || last_batch !== 1'b1 || ref_idx !== 4'd0) begin
            errors++;
            $display("FAIL basic_beat1 got lv=%b lb=%b idx=%0d exp 1111 1 0",
                     lane_valid, last_batch, ref_idx);
        end
        wait_done(3, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || cyc != 18 || !lh || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b cyc=%0d lasths=%b busy=%b exp 1 18 1 0",
                     gd, cyc, lh, busy);
        end
        checks++;
        if (beats != 16 || q.size() != 0) begin
            errors++;
            $display("FAIL basic_count got %0d left %0d exp 16 left 0", beats, q.size());
        end
    endtask

    task automatic test_partial();
        int cyc;
        bit gd, lh, vs;
        out_ready = 1'b1;
        do_start(6);
        wait_done(0, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || cyc != 14 || beats != 12 || q.size() != 0) begin
            errors++;
            $display("FAIL partial got done=%b cyc=%0d beats=%0d left=%0d exp 1 14 12 0",
                     gd, cyc, beats, q.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit gd, lh, vs;
        out_ready = 1'b1;
        do_start(8);
        wait_done(0, 1'b1, cyc, gd, lh, vs);
        checks++;
        if (!gd || !lh || beats != 16 || q.size() != 0) begin
            errors++;
            $display("FAIL backpressure got done=%b lasths=%b beats=%0d left=%0d exp 1 1 16 0",
                     gd, lh, beats, q.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_zero();
        int cyc;
        bit gd, lh, vs;
        do_start(0);
        wait_done(0, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || cyc != 2 || vs || beats != 0) begin
            errors++;
            $display("FAIL zero got done=%b cyc=%0d valid_seen=%b beats=%0d exp 1 2 0 0",
                     gd, cyc, vs, beats);
        end
    endtask

    task automatic test_clamp();
        int cyc;
        bit gd, lh, vs;
        do_start(20);
        wait_done(0, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || cyc != 66 || beats != 64 || q.size() != 0) begin
            errors++;
            $display("FAIL clamp got done=%b cyc=%0d beats=%0d left=%0d exp 1 66 64 0",
                     gd, cyc, beats, q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit gd, lh, vs, saw_done;
        do_start(8);
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h exp 0", all_out);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            saw_done = saw_done | done;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_done got 1 exp 0");
        end
        q.delete();
        @(posedge clock); #2 resetn = 1'b1;
        do_start(4);
        wait_done(0, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || cyc != 6 || beats != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL reset_restart got done=%b cyc=%0d beats=%0d left=%0d exp 1 6 4 0",
                     gd, cyc, beats, q.size());
        end
    endtask

    task automatic test_ignore_feed();
        int cyc;
        bit gd, lh, vs;
        do_start(8);
        repeat (3) @(negedge clock);
        @(posedge clock); #2;
        wr_en = 1'b1;
        wr_addr = 4'd3;
        wr_x = 16'hdead;
        wr_y = 16'hbeef;
        wr_z = 16'hcafe;
        start = 1'b1;
        num_points = 5'd2;
        @(posedge clock); #2;
        wr_en = 1'b0;
        start = 1'b0;
        wait_done(4, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || cyc != 18 || beats != 16 || q.size() != 0) begin
            errors++;
            $display("FAIL ignore_run got done=%b cyc=%0d beats=%0d left=%0d exp 1 18 16 0",
                     gd, cyc, beats, q.size());
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start got busy=%b exp 0", busy);
        end
        do_start(4);
        wait_done(0, 1'b0, cyc, gd, lh, vs);
        checks++;
        if (!gd || beats != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL ignore_storage got done=%b beats=%0d left=%0d exp 1 4 0",
                     gd, beats, q.size());
        end
    endtask

    initial begin
        test_reset();
        load_points();
        test_basic();
        test_partial();
        test_backpressure();
        test_zero();
        test_clamp();
        test_reset_mid();
        test_ignore_feed();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
